// File: rtl/player_life_pkg.sv
// Shared types and default constants for the per-player life manager.
package player_life_pkg;

   typedef enum logic [1:0] {
      ALIVE,
      INVULN,
      GAME_OVER
   } life_state_t;

   localparam int START_LIVES_D   = 3;
   localparam int MAX_LIVES_D     = 7;
   localparam int LIVES_W_D       = 3;
   localparam int INVULN_FRAMES_D = 90;
   localparam int BLINK_FRAMES_D  = 4;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Frame-enabled down-counter with load, done flag and blink-wrap strobe.
module frame_down_counter
   import player_life_pkg::*;
#(
   parameter int CNT_W        = 7,
   parameter int BLINK_FRAMES = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             frame_en,
   output logic             done,
   output logic             blink_wrap
);

   localparam int BW = cnt_w(BLINK_FRAMES);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BW-1:0]    blink_q, blink_d;

   always_comb begin
      cnt_d      = cnt_q;
      blink_d    = blink_q;
      blink_wrap = 1'b0;
      if (clr) begin
         cnt_d   = '0;
         blink_d = '0;
      end else if (load) begin
         cnt_d   = load_val;
         blink_d = '0;
      end else if (frame_en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
         if (blink_q == BLINK_LAST) begin
            blink_d    = '0;
            blink_wrap = 1'b1;
         end else begin
            blink_d = blink_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/player_life_manager.sv
// Per-player lives, frame-collapsed hit handling and blinking
// invulnerability window after a non-fatal hit.
module player_life_manager
   import player_life_pkg::*;
#(
   parameter int START_LIVES   = START_LIVES_D,
   parameter int MAX_LIVES     = MAX_LIVES_D,
   parameter int LIVES_W       = LIVES_W_D,
   parameter int INVULN_FRAMES = INVULN_FRAMES_D,
   parameter int BLINK_FRAMES  = BLINK_FRAMES_D
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               player_hit,
   input  logic               extra_life,
   input  logic               game_restart,
   output logic [LIVES_W-1:0] lives,
   output logic               player_invulnerable,
   output logic               player_visible,
   output logic               respawn_pulse,
   output logic               game_over
);

   localparam int INV_W = cnt_w(INVULN_FRAMES);
   localparam logic [LIVES_W:0] MAX_EXT = (LIVES_W+1)'(MAX_LIVES);

   life_state_t        state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic               hit_seen_q, hit_seen_d;
   logic               vis_q, vis_d;
   logic               resp_q, resp_d;

   logic               hit_now;
   logic [LIVES_W:0]   lives_ext, up_lives, net_lives;
   logic               inv_clr, inv_load, inv_frame_en;
   logic               inv_done, blink_wrap;

   function automatic logic [LIVES_W-1:0] sat(input logic [LIVES_W:0] v);
      return (v > MAX_EXT) ? MAX_EXT[LIVES_W-1:0] : v[LIVES_W-1:0];
   endfunction

   assign hit_now   = hit_seen_q | player_hit;
   assign lives_ext = {1'b0, lives_q};
   assign up_lives  = lives_ext + (LIVES_W+1)'(extra_life);
   // Lives are never 0 outside GAME_OVER; the guard keeps the subtract safe.
   assign net_lives = (lives_q == '0) ? up_lives
                                      : up_lives - (LIVES_W+1)'(1);

   assign inv_clr      = resetN | game_restart;
   assign inv_load     = (state_q == ALIVE) && startOfFrame && hit_now &&
                         (net_lives != '0);
   assign inv_frame_en = (state_q == INVULN) && startOfFrame;

   frame_down_counter #(
      .CNT_W        (INV_W),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_inv_cnt (
      .clk        (clk),
      .clr        (inv_clr),
      .load       (inv_load),
      .load_val   (INV_W'(INVULN_FRAMES - 1)),
      .frame_en   (inv_frame_en),
      .done       (inv_done),
      .blink_wrap (blink_wrap)
   );

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      hit_seen_d = hit_seen_q;
      vis_d      = vis_q;
      resp_d     = 1'b0;
      if (game_restart) begin
         state_d    = ALIVE;
         lives_d    = LIVES_W'(START_LIVES);
         hit_seen_d = 1'b0;
         vis_d      = 1'b1;
      end else begin
         unique case (state_q)
            ALIVE: begin
               hit_seen_d = hit_now;
               if (extra_life)
                  lives_d = sat(up_lives);
               if (startOfFrame) begin
                  hit_seen_d = 1'b0;
                  if (hit_now) begin
                     lives_d = sat(net_lives);
                     vis_d   = 1'b0;
                     if (net_lives == '0) begin
                        state_d = GAME_OVER;
                     end else begin
                        state_d = INVULN;
                        resp_d  = 1'b1;
                     end
                  end
               end
            end
            INVULN: begin
               hit_seen_d = 1'b0;
               if (extra_life)
                  lives_d = sat(up_lives);
               if (startOfFrame) begin
                  if (inv_done) begin
                     state_d = ALIVE;
                     vis_d   = 1'b1;
                  end else if (blink_wrap) begin
                     vis_d = ~vis_q;
                  end
               end
            end
            GAME_OVER: begin
               hit_seen_d = 1'b0;
               lives_d    = '0;
               vis_d      = 1'b0;
            end
            default: begin
               state_d = ALIVE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         state_q    <= ALIVE;
         lives_q    <= LIVES_W'(START_LIVES);
         hit_seen_q <= 1'b0;
         vis_q      <= 1'b1;
         resp_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lives_q    <= lives_d;
         hit_seen_q <= hit_seen_d;
         vis_q      <= vis_d;
         resp_q     <= resp_d;
      end
   end

   assign lives               = lives_q;
   assign player_invulnerable = (state_q != ALIVE);
   assign player_visible      = vis_q;
   assign respawn_pulse       = resp_q;
   assign game_over           = (state_q == GAME_OVER);

endmodule

// File: doc/player_life_manager.md
Name: player_life_manager

Overview:
- Downstream consumer of the collision controller's per-pixel player_hit level (one instance per player).
- Collapses hits to at most one life loss per frame, keeps the lives count, and runs a frame-counted invulnerability window with sprite blink.
- Drives player_invulnerable back to the collision controller, which gates further hits while it is high.
- Raises game_over when lives reach zero.

Parameters:
- START_LIVES, 3: lives loaded at reset/restart (1..MAX_LIVES).
- MAX_LIVES, 7: saturation ceiling for the lives counter.
- LIVES_W, 3: width of the lives counter; must satisfy 2^LIVES_W > MAX_LIVES.
- INVULN_FRAMES, 90: frames of invulnerability after a non-fatal hit (3 s at 30 Hz).
- BLINK_FRAMES, 4: frames per blink half-period while invulnerable.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous, active-high reset: asserted when 1, sampled on posedge clk.
- startOfFrame  in  1  one-cycle pulse at frame start (30 Hz).
- player_hit  in  1  per-pixel level from the collision controller; high on any cycle of the frame the player overlaps blast/enemy.
- extra_life  in  1  one-cycle pulse; the player collected a life power-up.
- game_restart  in  1  one-cycle pulse; reload lives and return to ALIVE.
- lives  out  LIVES_W  current life count.
- player_invulnerable  out  1  high in INVULN and GAME_OVER.
- player_visible  out  1  sprite draw enable: blink pattern in INVULN, 1 in ALIVE, 0 in GAME_OVER.
- respawn_pulse  out  1  one-cycle pulse on entry to INVULN; the player position module reloads spawn coordinates.
- game_over  out  1  high in GAME_OVER.

Behaviour:
- Reset values: state ALIVE, lives=START_LIVES, player_invulnerable=0, player_visible=1, respawn_pulse=0, game_over=0, hit_seen=0, inv_cnt=0, blink_cnt=0.
- Reset mid-operation: the same values apply on the next edge from any state; an in-flight hit_seen is discarded.
- States: ALIVE, INVULN, GAME_OVER.
- Hit capture (ALIVE only): hit_seen<=1 on any cycle with player_hit=1. Any number of hit pixels in a frame count as one hit.
- Frame boundary (cycle with startOfFrame=1), in ALIVE:
  - If hit_seen=1 (including a hit on this same cycle): clear hit_seen and decrement lives.
  - Post-decrement lives==0: go to GAME_OVER.
  - Otherwise: go to INVULN, load inv_cnt=INVULN_FRAMES-1, clear blink_cnt, assert respawn_pulse for exactly one cycle (the next cycle).
- Hit latency: a hit seen in frame N is applied at the startOfFrame that opens frame N+1. Outputs update one clk after that pulse (registered).
- INVULN:
  - player_hit is ignored and hit_seen is held at 0.
  - On each startOfFrame: if inv_cnt==0, go to ALIVE with player_visible=1; otherwise decrement inv_cnt and advance blink_cnt.
  - blink_cnt wraps at BLINK_FRAMES-1 and toggles player_visible on each wrap.
  - player_visible=0 on the first INVULN cycle.
- GAME_OVER: all hit and extra_life inputs are ignored; lives stays at 0. Exit is only via game_restart or reset.
- extra_life (ALIVE or INVULN): lives<=min(lives+1, MAX_LIVES) on the same edge, no frame alignment.
- Same-cycle extra_life and applied hit: net lives=lives-1+1, with saturation applied to the final value. No game over is possible on that cycle.
- game_restart: takes priority over all other inputs on the same cycle and has the reset effect.
- Counters never underflow: lives never wraps below 0, inv_cnt never decrements below 0.

Decomposition:
- Package player_life_pkg:
  - typedef enum logic[1:0] life_state_t {ALIVE, INVULN, GAME_OVER}.
  - Default constants for START_LIVES, MAX_LIVES, INVULN_FRAMES, BLINK_FRAMES.
- Sub-module frame_down_counter: frame-enabled down-counter with load, done flag and blink-wrap output.
  - Instantiated once for inv_cnt/blink_cnt.
  - Reusable for bomb fuse timers.

Test Plan:
- Reset, then 3 frames with no hits -> lives=3, player_invulnerable=0, player_visible=1, game_over=0 throughout.
- player_hit high for 50 cycles in frame 1 -> single decrement: lives=2 one clk after next startOfFrame, respawn_pulse exactly 1 cycle, player_invulnerable=1 for exactly 90 frames, then ALIVE.
- Hits every frame during INVULN -> lives stays 2. With BLINK_FRAMES=4, player_visible toggles every 4 frames, starting at 0.
- Hit in three separated ALIVE periods (START_LIVES=3) -> lives 2,1,0; game_over=1 after the third. A later extra_life leaves lives=0; game_restart restores lives=3, state ALIVE.
- extra_life pulses at lives=7 -> stays 7. Hit applied on the same cycle as extra_life with lives=1 -> lives=1, no game_over, enters INVULN.
- resetN asserted mid-INVULN (inv_cnt=40) -> next edge: ALIVE, lives=3, player_invulnerable=0, player_visible=1, respawn_pulse=0.
